// File: rtl/score_keeper.sv
// Pong game-flow controller: serve delay, play and game-over sequencing plus the
// two player score registers feeding the score display stage.
module score_keeper #(
  parameter int WIN_SCORE          = 11,
  parameter int SERVE_DELAY_FRAMES = 60
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_tick_i,
  input  logic       start_i,
  input  logic       goal_player_1_i,
  input  logic       goal_player_2_i,
  output logic [5:0] score_player_1_o,
  output logic [5:0] score_player_2_o,
  output logic       serve_o,
  output logic       serve_dir_o,
  output logic       ball_enable_o,
  output logic       game_over_o,
  output logic       winner_o
);

  localparam logic [5:0] WIN_VAL  = 6'(WIN_SCORE);
  localparam logic [7:0] DLY_LAST = 8'(SERVE_DELAY_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE_WAIT,
    S_SERVE,
    S_PLAY,
    S_GAME_OVER
  } state_t;

  state_t     r_state;
  logic [7:0] r_frame_cnt;
  logic [5:0] r_score_1;
  logic [5:0] r_score_2;
  logic       r_serve;
  logic       r_serve_dir;
  logic       r_ball_en;
  logic       r_game_over;
  logic       r_winner;

  logic [5:0] w_score_1_inc;
  logic [5:0] w_score_2_inc;

  assign w_score_1_inc = r_score_1 + 6'd1;
  assign w_score_2_inc = r_score_2 + 6'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_frame_cnt <= 8'd0;
      r_score_1   <= 6'd0;
      r_score_2   <= 6'd0;
      r_serve     <= 1'b0;
      r_serve_dir <= 1'b0;
      r_ball_en   <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= 1'b0;
    end else begin
      r_serve <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state     <= S_SERVE_WAIT;
            r_frame_cnt <= 8'd0;
          end
        end
        S_SERVE_WAIT: begin
          if (frame_tick_i) begin
            if (r_frame_cnt == DLY_LAST) begin
              r_state <= S_SERVE;
              r_serve <= 1'b1;
            end else begin
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end
        end
        S_SERVE: begin
          r_state   <= S_PLAY;
          r_ball_en <= 1'b1;
        end
        S_PLAY: begin
          // Simultaneous goals are a let: replay the serve without scoring.
          if (goal_player_1_i && goal_player_2_i) begin
            r_state     <= S_SERVE_WAIT;
            r_frame_cnt <= 8'd0;
            r_ball_en   <= 1'b0;
          end else if (goal_player_1_i) begin
            r_score_1   <= w_score_1_inc;
            r_serve_dir <= 1'b1;
            r_ball_en   <= 1'b0;
            if (w_score_1_inc == WIN_VAL) begin
              r_state     <= S_GAME_OVER;
              r_game_over <= 1'b1;
              r_winner    <= 1'b0;
            end else begin
              r_state     <= S_SERVE_WAIT;
              r_frame_cnt <= 8'd0;
            end
          end else if (goal_player_2_i) begin
            r_score_2   <= w_score_2_inc;
            r_serve_dir <= 1'b0;
            r_ball_en   <= 1'b0;
            if (w_score_2_inc == WIN_VAL) begin
              r_state     <= S_GAME_OVER;
              r_game_over <= 1'b1;
              r_winner    <= 1'b1;
            end else begin
              r_state     <= S_SERVE_WAIT;
              r_frame_cnt <= 8'd0;
            end
          end
        end
        S_GAME_OVER: begin
          if (start_i) begin
            r_state     <= S_SERVE_WAIT;
            r_frame_cnt <= 8'd0;
            r_score_1   <= 6'd0;
            r_score_2   <= 6'd0;
            r_serve_dir <= 1'b0;
            r_winner    <= 1'b0;
            r_game_over <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign score_player_1_o = r_score_1;
  assign score_player_2_o = r_score_2;
  assign serve_o          = r_serve;
  assign serve_dir_o      = r_serve_dir;
  assign ball_enable_o    = r_ball_en;
  assign game_over_o      = r_game_over;
  assign winner_o         = r_winner;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with WIN_SCORE=3 and SERVE_DELAY_FRAMES=3.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       g1 = 1'b0;
  logic       g2 = 1'b0;
  logic [5:0] s1;
  logic [5:0] s2;
  logic       serve;
  logic       dir;
  logic       ball_en;
  logic       game_over;
  logic       winner;

  int total = 0;
  int bad   = 0;

  score_keeper #(.WIN_SCORE(3), .SERVE_DELAY_FRAMES(3)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .frame_tick_i     (frame_tick),
    .start_i          (start),
    .goal_player_1_i  (g1),
    .goal_player_2_i  (g2),
    .score_player_1_o (s1),
    .score_player_2_o (s2),
    .serve_o          (serve),
    .serve_dir_o      (dir),
    .ball_enable_o    (ball_en),
    .game_over_o      (game_over),
    .winner_o         (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_goal(input logic a, input logic b);
    g1 = a; g2 = b; step(); g1 = 1'b0; g2 = 1'b0;
  endtask

  // Three ticks separated by `gap` idle cycles; leaves the bench on the SERVE cycle.
  task automatic ticks_to_serve(input int gap, input string tag);
    for (int i = 0; i < 3; i++) begin
      repeat (gap) step();
      if (i < 2) begin
        pulse_tick();
        check({tag, "_noserve_early"}, {7'd0, serve}, 8'd0);
      end else begin
        pulse_tick();
      end
    end
    check({tag, "_serve_hi"}, {7'd0, serve}, 8'd1);
    check({tag, "_ball_lo_on_serve"}, {7'd0, ball_en}, 8'd0);
  endtask

  task automatic enter_play(input string tag);
    ticks_to_serve(2, tag);
    step();
    check({tag, "_serve_lo"}, {7'd0, serve}, 8'd0);
    check({tag, "_ball_hi"}, {7'd0, ball_en}, 8'd1);
  endtask

  initial begin
    // Reset state
    step(); step();
    check("rst_s1", {2'd0, s1}, 8'd0);
    check("rst_s2", {2'd0, s2}, 8'd0);
    check("rst_flags", {3'd0, serve, dir, ball_en, game_over, winner}, 8'd0);
    rst = 1'b0;
    repeat (4) step();
    check("idle_flags", {3'd0, serve, dir, ball_en, game_over, winner}, 8'd0);

    // Goal and ticks in IDLE ignored
    pulse_goal(1'b1, 1'b0);
    pulse_tick();
    check("idle_goal_s1", {2'd0, s1}, 8'd0);
    check("idle_tick_serve", {7'd0, serve}, 8'd0);

    // Start, then serve delay with 10-cycle tick spacing and a goal inside SERVE_WAIT
    pulse_start();
    check("start_s1", {2'd0, s1}, 8'd0);
    pulse_goal(1'b0, 1'b1);
    check("wait_goal_s2", {2'd0, s2}, 8'd0);
    ticks_to_serve(9, "serve1");
    // Goal on the SERVE cycle is ignored
    pulse_goal(1'b1, 1'b0);
    check("serve_goal_s1", {2'd0, s1}, 8'd0);
    check("serve1_serve_lo", {7'd0, serve}, 8'd0);
    check("serve1_ball_hi", {7'd0, ball_en}, 8'd1);

    // start and tick in PLAY have no effect
    pulse_start();
    pulse_tick();
    check("play_start_ball", {7'd0, ball_en}, 8'd1);
    check("play_start_serve", {7'd0, serve}, 8'd0);

    // Player 1 scores
    pulse_goal(1'b1, 1'b0);
    check("g1_s1", {2'd0, s1}, 8'd1);
    check("g1_dir", {7'd0, dir}, 8'd1);
    check("g1_ball", {7'd0, ball_en}, 8'd0);
    check("g1_go", {7'd0, game_over}, 8'd0);

    // Player 2 scores
    enter_play("serve2");
    pulse_goal(1'b0, 1'b1);
    check("g2_s2", {2'd0, s2}, 8'd1);
    check("g2_dir", {7'd0, dir}, 8'd0);

    enter_play("serve3");
    pulse_goal(1'b0, 1'b1);
    check("g2b_s2", {2'd0, s2}, 8'd2);
    enter_play("serve4");
    pulse_goal(1'b1, 1'b0);
    check("g1b_s1", {2'd0, s1}, 8'd2);
    check("g1b_dir", {7'd0, dir}, 8'd1);

    // Simultaneous goals at 2:2
    enter_play("serve5");
    pulse_goal(1'b1, 1'b1);
    check("let_s1", {2'd0, s1}, 8'd2);
    check("let_s2", {2'd0, s2}, 8'd2);
    check("let_dir", {7'd0, dir}, 8'd1);
    check("let_ball", {7'd0, ball_en}, 8'd0);
    enter_play("serve6");

    // Winning goal for player 2
    pulse_goal(1'b0, 1'b1);
    check("win_s2", {2'd0, s2}, 8'd3);
    check("win_go", {7'd0, game_over}, 8'd1);
    check("win_winner", {7'd0, winner}, 8'd1);
    check("win_ball", {7'd0, ball_en}, 8'd0);

    // Frozen in GAME_OVER
    pulse_goal(1'b1, 1'b0);
    pulse_goal(1'b0, 1'b1);
    repeat (4) pulse_tick();
    check("go_frozen_s1", {2'd0, s1}, 8'd2);
    check("go_frozen_s2", {2'd0, s2}, 8'd3);
    check("go_frozen_flags", {3'd0, serve, dir, ball_en, game_over, winner}, 8'b00011);

    // Restart
    pulse_start();
    check("restart_s1", {2'd0, s1}, 8'd0);
    check("restart_s2", {2'd0, s2}, 8'd0);
    check("restart_flags", {3'd0, serve, dir, ball_en, game_over, winner}, 8'd0);
    enter_play("serve7");
    check("serve7_dir", {7'd0, dir}, 8'd0);
    pulse_goal(1'b0, 1'b1);
    check("after_restart_s2", {2'd0, s2}, 8'd1);
    enter_play("serve8");

    // Asynchronous reset in the middle of PLAY
    #3 rst = 1'b1;
    #1;
    check("arst_s2", {2'd0, s2}, 8'd0);
    check("arst_flags", {3'd0, serve, dir, ball_en, game_over, winner}, 8'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse_tick();
      check("post_rst_idle", {3'd0, serve, dir, ball_en, game_over, winner}, 8'd0);
    end
    pulse_start();
    enter_play("serve9");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
